fetch_stage: RTL and testbench

- Instruction-fetch stage. It sits directly upstream of the decode stage and drives that stage's `input_inst` and `input_reg_pc`.
- It owns the PC and issues one outstanding instruction-memory read at a time over a valid/ready request plus valid response handshake.
- It holds its output while the pipeline is stalled.
- On a taken branch/jump redirect from execute, it flushes by presenting NOP bubbles and drops any in-flight response.

---
 rtl/fetch_stage_pkg.sv | 13 +
 rtl/fetch_hold_buf.sv | 31 +++
 rtl/fetch_stage.sv | 141 ++++++++++++++
 tb/tb_fetch_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bubble encoding and fetch FSM states.
package fetch_stage_pkg;

    // addi x0,x0,0
    localparam logic [31:0] FETCH_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {inst, pc} holding register that parks a response which arrived while decode was stalled.
module fetch_hold_buf
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_inst,
    input  logic [31:0] load_pc,
    output logic        full,
    output logic [31:0] inst,
    output logic [31:0] pc
);

    // clear wins so a redirect always empties the entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            inst <= FETCH_NOP;
            pc   <= 32'h0000_0000;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            inst <= load_inst;
            pc   <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one memory read in flight and feeds decode.
//   state  | meaning
//   S_REQ  | request valid at pc, waiting for mem_req_ready
//   S_WAIT | request accepted, waiting for the response (dropped if discard is set)
//   S_HOLD | response parked in the hold buffer until stall_flg falls
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = FETCH_NOP
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        branch_hit,
    input  logic [31:0] branch_target,
    input  logic        stall_flg,
    output logic [31:0] output_inst,
    output logic [31:0] output_reg_pc
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  req_pc, req_pc_nxt;
    logic [31:0]  inst_nxt, out_pc_nxt;
    logic [31:0]  target;
    logic         discard, discard_nxt;
    logic         started;
    logic         accept;
    logic         buf_load, buf_clear, buf_full;
    logic [31:0]  buf_inst, buf_pc;

    assign target        = branch_target & 32'hFFFF_FFFC;
    // started keeps the request low for the first cycle out of reset
    assign mem_req_valid = started && (state == S_REQ) && !buf_full;
    assign mem_req_addr  = pc;
    assign accept        = mem_req_valid && mem_req_ready;

    fetch_hold_buf u_hold_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (buf_load),
        .clear     (buf_clear),
        .load_inst (mem_resp_data),
        .load_pc   (req_pc),
        .full      (buf_full),
        .inst      (buf_inst),
        .pc        (buf_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_REQ;
            pc            <= RESET_PC;
            req_pc        <= RESET_PC;
            discard       <= 1'b0;
            started       <= 1'b0;
            output_inst   <= NOP_INST;
            output_reg_pc <= RESET_PC;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            req_pc        <= req_pc_nxt;
            discard       <= discard_nxt;
            started       <= 1'b1;
            output_inst   <= inst_nxt;
            output_reg_pc <= out_pc_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        req_pc_nxt  = req_pc;
        discard_nxt = discard;
        inst_nxt    = output_inst;
        out_pc_nxt  = output_reg_pc;
        buf_load    = 1'b0;
        buf_clear   = 1'b0;

        if (branch_hit) begin
            // redirect overrides stall and any response; req_pc follows so bubbles carry the target
            pc_nxt      = target;
            req_pc_nxt  = target;
            inst_nxt    = NOP_INST;
            out_pc_nxt  = target;
            buf_clear   = 1'b1;
            discard_nxt = 1'b0;
            state_nxt   = S_REQ;
            if ((state == S_WAIT) && !mem_resp_valid) begin
                discard_nxt = 1'b1;
                state_nxt   = S_WAIT;
            end else if (accept) begin
                discard_nxt = 1'b1;
                state_nxt   = S_WAIT;
            end
        end else begin
            if (!stall_flg) begin
                inst_nxt   = NOP_INST;
                out_pc_nxt = req_pc;
            end
            unique case (state)
                S_REQ: begin
                    if (accept) begin
                        req_pc_nxt = pc;
                        pc_nxt     = pc + 32'd4;
                        state_nxt  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        state_nxt = S_REQ;
                        if (discard) begin
                            discard_nxt = 1'b0;
                        end else if (!stall_flg) begin
                            inst_nxt   = mem_resp_data;
                            out_pc_nxt = req_pc;
                        end else begin
                            buf_load  = 1'b1;
                            state_nxt = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_flg) begin
                        inst_nxt   = buf_inst;
                        out_pc_nxt = buf_pc;
                        buf_clear  = 1'b1;
                        state_nxt  = S_REQ;
                    end
                end
                default: state_nxt = S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small instruction-memory responder (data = addr ^ 0xA5A5A5A5).
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] MASK = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data  = 32'h0;
    logic        branch_hit, stall_flg;
    logic [31:0] branch_target;
    logic [31:0] output_inst, output_reg_pc;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_resp_valid = 1'b0;
    logic [31:0] w_resp_data  = 32'h0;
    logic [31:0] w_inst, w_pc;

    int n_checks = 0;
    int n_fail   = 0;

    int          resp_lat;
    bit          acc_flag = 1'b0;
    logic [31:0] acc_addr = 32'h0;
    int          acc_lat  = 1;
    bit          inflight = 1'b0;
    int          cnt      = 0;
    logic [31:0] fl_addr  = 32'h0;

    bit          w_acc_flag = 1'b0;
    logic [31:0] w_acc_addr = 32'h0;
    logic [31:0] w_acc_q[$];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .branch_hit     (branch_hit),
        .branch_target  (branch_target),
        .stall_flg      (stall_flg),
        .output_inst    (output_inst),
        .output_reg_pc  (output_reg_pc)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req_valid  (w_req_valid),
        .mem_req_ready  (1'b1),
        .mem_req_addr   (w_req_addr),
        .mem_resp_valid (w_resp_valid),
        .mem_resp_data  (w_resp_data),
        .branch_hit     (1'b0),
        .branch_target  (32'h0),
        .stall_flg      (1'b0),
        .output_inst    (w_inst),
        .output_reg_pc  (w_pc)
    );

    // a response must never coincide with an open request
    a_resp_proto: assert property (@(posedge clk) disable iff (!rst_n)
        mem_resp_valid |-> !mem_req_valid);

    always @(posedge clk) begin
        acc_flag = rst_n && mem_req_valid && mem_req_ready;
        acc_addr = mem_req_addr;
        acc_lat  = resp_lat;
        w_acc_flag = rst_n && w_req_valid;
        w_acc_addr = w_req_addr;
        if (w_acc_flag) w_acc_q.push_back(w_req_addr);
    end

    always @(negedge clk) begin
        mem_resp_valid = 1'b0;
        if (!rst_n) begin
            inflight = 1'b0;
        end else begin
            if (acc_flag) begin
                inflight = 1'b1;
                cnt      = acc_lat;
                fl_addr  = acc_addr;
            end
            if (inflight) begin
                if (cnt <= 1) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = fl_addr ^ MASK;
                    inflight       = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        w_resp_valid = rst_n && w_acc_flag;
        w_resp_data  = w_acc_addr ^ MASK;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic [31:0] inst, input logic [31:0] pc);
        check_val({tag, "_inst"}, output_inst, inst);
        check_val({tag, "_pc"}, output_reg_pc, pc);
    endtask

    task automatic check_req(input string tag, input logic v, input logic [31:0] addr);
        check_val({tag, "_valid"}, 32'(mem_req_valid), 32'(v));
        if (v) check_val({tag, "_addr"}, mem_req_addr, addr);
    endtask

    initial begin
        mem_req_ready = 1'b1;
        stall_flg     = 1'b0;
        branch_hit    = 1'b0;
        branch_target = 32'h0;
        resp_lat      = 1;
        rst_n         = 1'b1;
        #1 rst_n      = 1'b0;

        tick();
        check_val("rst_valid", 32'(mem_req_valid), 32'd0);
        check_val("rst_addr", mem_req_addr, 32'h0);
        check_out("rst", NOP, 32'h0);
        check_val("wrap_rst_valid", 32'(w_req_valid), 32'd0);
        check_val("wrap_rst_addr", w_req_addr, 32'hFFFF_FFFC);
        check_val("wrap_rst_inst", w_inst, NOP);
        check_val("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
        tick();
        rst_n = 1'b1;

        // streaming fetch, ready always high, 1-cycle response
        tick();
        check_req("s0", 1'b1, 32'h0);
        check_out("s0", NOP, 32'h0);
        tick();
        check_req("s1", 1'b0, 32'h0);
        tick();
        check_out("s2", 32'hA5A5A5A5, 32'h0);
        check_req("s2", 1'b1, 32'h4);

        // memory back-pressure
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_req("rdy0", 1'b1, 32'h4);
        end
        check_out("rdy0_bub", NOP, 32'h0);
        mem_req_ready = 1'b1;
        tick();
        check_req("rdy1", 1'b0, 32'h0);
        tick();
        check_out("rdy1", 32'hA5A5A5A1, 32'h4);
        check_req("rdy1b", 1'b1, 32'h8);

        if (w_acc_q.size() < 2) begin
            check_val("wrap_cnt", 32'(w_acc_q.size()), 32'd2);
        end else begin
            check_val("wrap_a0", w_acc_q[0], 32'hFFFF_FFFC);
            check_val("wrap_a1", w_acc_q[1], 32'h0000_0000);
        end

        // response lands while stalled: held in buffer, released one edge after stall drops
        stall_flg = 1'b1;
        tick();
        check_out("stl0", 32'hA5A5A5A1, 32'h4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_req("stl1", 1'b0, 32'h0);
            check_out("stl1", 32'hA5A5A5A1, 32'h4);
        end
        stall_flg = 1'b0;
        tick();
        check_out("stl2", 32'hA5A5A5AD, 32'h8);
        check_req("stl2", 1'b1, 32'hC);
        tick();
        check_out("stl3", NOP, 32'h8);
        tick();
        check_out("stl4", 32'hA5A5A5A9, 32'hC);
        check_req("stl4", 1'b1, 32'h10);

        // redirect while waiting on a slow response
        resp_lat = 3;
        tick();
        branch_hit    = 1'b1;
        branch_target = 32'h0000_0102;
        tick();
        branch_hit = 1'b0;
        check_out("br0", NOP, 32'h100);
        check_req("br0", 1'b0, 32'h0);
        tick();
        tick();
        check_out("br1", NOP, 32'h100);
        check_req("br1", 1'b1, 32'h100);
        resp_lat = 1;
        tick();
        tick();
        check_out("br2", 32'hA5A5A4A5, 32'h100);
        check_req("br2", 1'b1, 32'h104);

        // redirect and stall together with a response arriving
        tick();
        stall_flg     = 1'b1;
        branch_hit    = 1'b1;
        branch_target = 32'h0000_0200;
        tick();
        branch_hit = 1'b0;
        stall_flg  = 1'b0;
        check_out("brs0", NOP, 32'h200);
        check_req("brs0", 1'b1, 32'h200);
        tick();
        tick();
        check_out("brs1", 32'hA5A5A7A5, 32'h200);

        // redirect in the same cycle a request is accepted
        branch_hit    = 1'b1;
        branch_target = 32'h0000_0300;
        tick();
        branch_hit = 1'b0;
        check_out("bra0", NOP, 32'h300);
        check_req("bra0", 1'b0, 32'h0);
        tick();
        check_out("bra1", NOP, 32'h300);
        check_req("bra1", 1'b1, 32'h300);

        // asynchronous reset in the middle of a wait
        resp_lat = 4;
        tick();
        check_req("ar0", 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check_val("ar_valid", 32'(mem_req_valid), 32'd0);
        check_val("ar_addr", mem_req_addr, 32'h0);
        check_out("ar", NOP, 32'h0);
        check_val("ar_wrap_addr", w_req_addr, 32'hFFFF_FFFC);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
